amstrad_mem_arbiter: RTL and testbench
======================================

AMSTRAD_MEM_ARBITER -- requirements
Module: amstrad_mem_arbiter

Interface
REQ-001 Parameter VID_PAGE, default 7'h00: byte-address bits [22:16] of every video fetch.
REQ-002 Parameter DMA_EN, default 1: when 0, dma_req is ignored and dma_ack stays 0.
REQ-003 clk  in  1: single system clock; all logic is on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 ce_4p  in  1: 4 MHz clock enable.
REQ-006 phase  in  2: CPU/video slot phase, sampled when ce_4p=1.
REQ-007 vid_addr  in  15: video word address.
REQ-008 vid_dout  out  16: last fetched video word.
REQ-009 vid_valid  out  1: one-cycle pulse when vid_dout updates.
REQ-010 cpu_rd, cpu_wr  in  1 each: level memory-read and memory-write strobes.
REQ-011 cpu_addr  in  23: CPU byte address.
REQ-012 cpu_din  in  8: CPU write data.
REQ-013 cpu_dout  out  8: CPU read data.
REQ-014 cpu_ready  out  1: when 0, the CPU is held in wait.
REQ-015 dma_req  in  1: loader write request, level.
REQ-016 dma_addr  in  23: loader byte address.
REQ-017 dma_din  in  8: loader write data.
REQ-018 dma_ack  out  1: one-cycle pulse when the loader write completes.
REQ-019 mem_req  out  1: memory command valid, level.
REQ-020 mem_we  out  1: memory write enable.
REQ-021 mem_addr  out  23: memory byte address.
REQ-022 mem_din  out  8: memory write data.
REQ-023 mem_dout  in  16: memory read data, word-aligned.
REQ-024 mem_ack  in  1: one-cycle pulse, command complete.

Function
REQ-025 The FSM SHALL have states IDLE, VID, CPU, DMA; exactly one memory command is outstanding at a time.
REQ-026 mem_req SHALL be 1 exactly in VID, CPU and DMA; mem_addr, mem_we and mem_din SHALL be registered at issue and held stable until mem_ack.
REQ-027 On ce_4p with phase==0, vid_pend SHALL be set and vid_addr latched.
REQ-028 Priority in IDLE: vid_pend > CPU pending > DMA pending; a command SHALL issue on the cycle after the request is detected (1-cycle latency).
REQ-029 Video command: mem_addr={VID_PAGE, vid_addr_latched, 1'b0}, mem_we=0.
REQ-030 On mem_ack in VID: vid_dout<=mem_dout, vid_valid=1 for 1 cycle, vid_pend cleared, next state IDLE.
REQ-031 If vid_pend is set while busy, video SHALL be issued immediately after the current mem_ack; a second phase-0 tick while vid_pend is still set overwrites the latched address (newest wins).
REQ-032 CPU pending = (cpu_rd|cpu_wr) & ~cpu_done; cpu_wr takes precedence if both are asserted.
REQ-033 CPU write: mem_we=1, mem_din=cpu_din, mem_addr=cpu_addr.
REQ-034 CPU read: mem_addr=cpu_addr; on mem_ack, cpu_dout<=cpu_addr[0] ? mem_dout[15:8] : mem_dout[7:0].
REQ-035 On CPU mem_ack, cpu_done SHALL be set; cpu_done clears when cpu_rd=cpu_wr=0; cpu_dout holds until the next CPU read completes.
REQ-036 cpu_ready = ~(cpu_rd|cpu_wr) | cpu_done.
REQ-037 DMA write: mem_we=1, mem_addr=dma_addr, mem_din=dma_din.
REQ-038 DMA completion: on mem_ack, dma_ack=1 for 1 cycle; the requester must drop dma_req or present the next byte in the cycle after dma_ack.
REQ-039 DMA is served only in IDLE with no video and no CPU pending; DMA starvation by the CPU is permitted.
REQ-040 mem_ack in IDLE SHALL be ignored.
REQ-041 mem_ack and a phase-0 tick in the same cycle: complete the current command; video issues next.

Reset
REQ-042 On reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, vid_dout=0, vid_valid=0, cpu_dout=8'hFF, cpu_done=0, dma_ack=0, vid_pend=0.
REQ-043 Reset mid-command SHALL abandon the command; a late mem_ack after reset is ignored per REQ-040.

Structure
REQ-044 The state encoding and the requester enum (VID/CPU/DMA) SHALL live in the shared package amstrad_pkg.
REQ-045 The block is a single module; no sub-module.

Verification
REQ-046 IDLE, phase-0 tick, vid_addr=15'h1234, ack after 3 cycles with mem_dout=16'hBEEF -> mem_addr=23'h002468, vid_dout=16'hBEEF, one vid_valid pulse.
REQ-047 cpu_rd at 23'h04001, mem_dout=16'hA55A -> cpu_ready=0 until ack, then cpu_dout=8'hA5, cpu_ready=1; exactly one command issued while cpu_rd stays high.
REQ-048 cpu_wr and a phase-0 tick in the same cycle -> video is issued first, CPU write second with mem_we=1; cpu_ready stays 0 throughout.
REQ-049 dma_req held while cpu_rd is pending -> CPU is served first, then DMA; exactly one dma_ack; with DMA_EN=0 the DMA is never issued.
REQ-050 Reset asserted during VID, then mem_ack arrives 2 cycles later -> mem_req=0 and vid_valid stays 0.

Source files
------------

// File: rtl/amstrad_pkg.sv
// Shared types for the Amstrad memory arbiter: FSM state encoding,
// requester identities and the byte-lane helper used on CPU reads.
package amstrad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2,
    ST_DMA  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    RQ_VID = 2'd0,
    RQ_CPU = 2'd1,
    RQ_DMA = 2'd2
  } requester_e;

  // Memory returns 16-bit words; odd byte addresses live in the high lane.
  function automatic logic [7:0] pick_byte(input logic odd, input logic [15:0] word);
    return odd ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/amstrad_mem_arbiter.sv
// Single-port memory arbiter shared by video fetch, CPU and a DMA loader.
// Memory handshake: mem_req is a level that stays high, with mem_addr,
// mem_we and mem_din frozen, from the cycle a command issues until the
// cycle mem_ack pulses; exactly one command is outstanding at a time and
// every command returns through IDLE. mem_ack seen in IDLE is ignored.
module amstrad_mem_arbiter
  import amstrad_pkg::*;
#(
  parameter logic [6:0] VID_PAGE = 7'h00,
  parameter bit         DMA_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_4p,
  input  logic [1:0]  phase,
  input  logic [14:0] vid_addr,
  output logic [15:0] vid_dout,
  output logic        vid_valid,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic [22:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic        dma_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  arb_state_e  state_q;
  logic        mem_req_q, mem_we_q;
  logic [22:0] mem_addr_q;
  logic [7:0]  mem_din_q;
  logic [15:0] vid_dout_q;
  logic        vid_valid_q;
  logic [7:0]  cpu_dout_q;
  logic        cpu_done_q;
  logic        dma_ack_q;
  logic        vid_pend_q;
  logic [14:0] vid_addr_q;

  logic        tick;
  logic        cpu_act;
  logic        vid_want, cpu_want, dma_want;
  logic [14:0] vid_addr_d;
  logic        grant_valid;
  requester_e  grant;

  // A phase-0 tick counts as a video request in the same cycle, so a tick
  // arriving together with a CPU strobe still wins arbitration.
  // dma_ack_q masks dma_req while the requester reacts to the ack, so the
  // byte just written is never issued twice.
  always_comb begin
    tick       = ce_4p & (phase == 2'd0);
    cpu_act    = cpu_rd | cpu_wr;
    vid_want   = vid_pend_q | tick;
    vid_addr_d = tick ? vid_addr : vid_addr_q;
    cpu_want   = cpu_act & ~cpu_done_q;
    dma_want   = DMA_EN & dma_req & ~dma_ack_q;
  end

  // Fixed priority: video, then CPU, then DMA.
  always_comb begin
    grant_valid = 1'b0;
    grant       = RQ_VID;
    if (vid_want) begin
      grant_valid = 1'b1;
      grant       = RQ_VID;
    end else if (cpu_want) begin
      grant_valid = 1'b1;
      grant       = RQ_CPU;
    end else if (dma_want) begin
      grant_valid = 1'b1;
      grant       = RQ_DMA;
    end
  end

  // Arbiter FSM: issues one command from IDLE, waits for mem_ack, returns.
  // vid_pend_q means "video waiting to issue"; an in-flight fetch is
  // represented by ST_VID, so a tick during ST_VID queues the next fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      vid_dout_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= 8'hFF;
      cpu_done_q  <= 1'b0;
      dma_ack_q   <= 1'b0;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
    end else begin
      vid_valid_q <= 1'b0;
      dma_ack_q   <= 1'b0;

      if (state_q == ST_IDLE && grant_valid && grant == RQ_VID) begin
        vid_pend_q <= 1'b0;
      end else if (tick) begin
        vid_pend_q <= 1'b1;
        vid_addr_q <= vid_addr;
      end

      if (state_q == ST_CPU && mem_ack) begin
        cpu_done_q <= 1'b1;
      end else if (!cpu_act) begin
        cpu_done_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            mem_req_q <= 1'b1;
            case (grant)
              RQ_VID: begin
                state_q    <= ST_VID;
                mem_we_q   <= 1'b0;
                mem_addr_q <= {VID_PAGE, vid_addr_d, 1'b0};
                mem_din_q  <= 8'h00;
              end
              RQ_CPU: begin
                state_q    <= ST_CPU;
                mem_we_q   <= cpu_wr;
                mem_addr_q <= cpu_addr;
                mem_din_q  <= cpu_wr ? cpu_din : 8'h00;
              end
              default: begin
                state_q    <= ST_DMA;
                mem_we_q   <= 1'b1;
                mem_addr_q <= dma_addr;
                mem_din_q  <= dma_din;
              end
            endcase
          end
        end
        ST_VID: begin
          if (mem_ack) begin
            vid_dout_q  <= mem_dout;
            vid_valid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_CPU: begin
          if (mem_ack) begin
            if (!mem_we_q) cpu_dout_q <= pick_byte(mem_addr_q[0], mem_dout);
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          if (mem_ack) begin
            dma_ack_q <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign vid_dout  = vid_dout_q;
  assign vid_valid = vid_valid_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ready = ~cpu_act | cpu_done_q;
  assign dma_ack   = dma_ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Bench for amstrad_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_amstrad_mem_arbiter;
  import amstrad_pkg::*;

  localparam logic [6:0] VID_PAGE = 7'h00;
  localparam int O_NONE = 0, O_VID = 1, O_CPU = 2, O_DMA = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ce_4p, cpu_rd, cpu_wr, dma_req, mem_ack;
  logic [1:0]  phase;
  logic [14:0] vid_addr;
  logic [22:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_din, dma_din;
  logic [15:0] mem_dout;

  logic [15:0] vid_dout;
  logic        vid_valid, cpu_ready, dma_ack, mem_req, mem_we;
  logic [7:0]  cpu_dout, mem_din;
  logic [22:0] mem_addr;
  logic [1:0]  dbg_state;

  logic [15:0] d2_vid_dout;
  logic        d2_vid_valid, d2_cpu_ready, d2_dma_ack, d2_mem_req, d2_mem_we;
  logic [7:0]  d2_cpu_dout, d2_mem_din;
  logic [22:0] d2_mem_addr;
  logic [1:0]  d2_dbg_state;

  amstrad_mem_arbiter #(.VID_PAGE(VID_PAGE), .DMA_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .ce_4p(ce_4p), .phase(phase), .vid_addr(vid_addr),
    .vid_dout(vid_dout), .vid_valid(vid_valid), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ack(dma_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  amstrad_mem_arbiter #(.VID_PAGE(VID_PAGE), .DMA_EN(1'b0)) u_dut_nodma (
    .clk(clk), .reset(reset), .ce_4p(ce_4p), .phase(phase), .vid_addr(vid_addr),
    .vid_dout(d2_vid_dout), .vid_valid(d2_vid_valid), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(d2_cpu_dout), .cpu_ready(d2_cpu_ready),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ack(d2_dma_ack),
    .mem_req(d2_mem_req), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_din(d2_mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .dbg_state(d2_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          resp_en = 1'b1;
  bit          resp_rand = 1'b0;
  bit          stray_en = 1'b0;
  int          resp_delay = 3;
  logic [15:0] resp_data = 16'h0000;
  int          resp_cnt = 0;
  bit          ack_sent = 1'b0;

  always @(negedge clk) begin
    if (resp_en) begin
      mem_ack = 1'b0;
      if (resp_rand) mem_dout = 16'($urandom);
      if (mem_req && !ack_sent) begin
        resp_cnt++;
        if (resp_cnt >= resp_delay) begin
          mem_ack  = 1'b1;
          ack_sent = 1'b1;
          resp_cnt = 0;
          if (!resp_rand) mem_dout = resp_data;
          else resp_delay = $urandom_range(1, 4);
        end
      end else if (!mem_req) begin
        ack_sent = 1'b0;
        resp_cnt = 0;
        if (stray_en && $urandom_range(0, 15) == 0) mem_ack = 1'b1;
      end
    end
  end

  // ---------------- command log and pulse counters ----------------
  logic [31:0] cmd_q[$];
  bit prev_req = 1'b0, d2_prev_req = 1'b0;
  int vv_cnt = 0, dack_cnt = 0, d2_dack_cnt = 0, d2_cmd_cnt = 0;

  always @(negedge clk) begin
    if (mem_req && !prev_req) cmd_q.push_back({mem_we, mem_addr, mem_din});
    if (d2_mem_req && !d2_prev_req) d2_cmd_cnt++;
    prev_req    = mem_req;
    d2_prev_req = d2_mem_req;
    if (vid_valid) vv_cnt++;
    if (dma_ack) dack_cnt++;
    if (d2_dma_ack) d2_dack_cnt++;
  end

  // ---------------- reference model ----------------
  // Transaction view: who owns the memory, what is waiting, what each
  // requester should see after a completion.
  int          m_owner = O_NONE;
  bit          m_vpend = 1'b0, m_cdone = 1'b0, m_dack = 1'b0, m_vvalid = 1'b0;
  bit          m_req = 1'b0, m_we = 1'b0;
  logic [14:0] m_vaddr = '0;
  logic [22:0] m_addr = '0;
  logic [7:0]  m_din = '0, m_cdout = 8'hFF;
  logic [15:0] m_vdout = '0;

  always @(posedge clk) begin
    bit tick, prev_dack, cpu_finished;
    tick = ce_4p && (phase == 2'd0);
    cpu_finished = 1'b0;
    if (reset) begin
      m_owner = O_NONE; m_vpend = 0; m_cdone = 0; m_dack = 0; m_vvalid = 0;
      m_req = 0; m_we = 0; m_addr = '0; m_din = '0; m_cdout = 8'hFF; m_vdout = '0;
    end else begin
      prev_dack = m_dack;
      m_vvalid  = 1'b0;
      m_dack    = 1'b0;
      if (m_owner == O_NONE) begin
        if (m_vpend || tick) begin
          m_owner = O_VID; m_req = 1; m_we = 0;
          m_addr  = {VID_PAGE, (tick ? vid_addr : m_vaddr), 1'b0};
          m_vpend = 0;
        end else if ((cpu_rd || cpu_wr) && !m_cdone) begin
          m_owner = O_CPU; m_req = 1; m_we = cpu_wr; m_addr = cpu_addr; m_din = cpu_din;
        end else if (dma_req && !prev_dack) begin
          m_owner = O_DMA; m_req = 1; m_we = 1; m_addr = dma_addr; m_din = dma_din;
        end
      end else begin
        if (mem_ack) begin
          if (m_owner == O_VID) begin
            m_vdout = mem_dout; m_vvalid = 1;
          end else if (m_owner == O_CPU) begin
            cpu_finished = 1;
            if (!m_we) m_cdout = m_addr[0] ? mem_dout[15:8] : mem_dout[7:0];
          end else begin
            m_dack = 1;
          end
          m_owner = O_NONE; m_req = 0;
        end
        if (tick) begin
          m_vpend = 1; m_vaddr = vid_addr;
        end
      end
      if (cpu_finished) m_cdone = 1;
      else if (!cpu_rd && !cpu_wr) m_cdone = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    check("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) begin
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_we) check("mem_din", 32'(mem_din), 32'(m_din));
    end
    check("vid_valid", 32'(vid_valid), 32'(m_vvalid));
    check("vid_dout", 32'(vid_dout), 32'(m_vdout));
    check("cpu_dout", 32'(cpu_dout), 32'(m_cdout));
    check("cpu_ready", 32'(cpu_ready), 32'(!(cpu_rd || cpu_wr) || m_cdone));
    check("dma_ack", 32'(dma_ack), 32'(m_dack));
    check("nodma_ack", 32'(d2_dma_ack), 32'(0));
    check("nodma_state", 32'(d2_dbg_state == ST_DMA), 32'(0));
  end

  // ---------------- driver ----------------
  bit found, ready_seen, dma_next;
  int sel;

  initial begin
    reset = 1; ce_4p = 0; phase = 2'd1; vid_addr = '0;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_din = '0;
    dma_req = 0; dma_addr = '0; dma_din = '0; mem_ack = 0; mem_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_din", 32'(mem_din), 32'(0));
    check("rst_vid_dout", 32'(vid_dout), 32'(0));
    check("rst_cpu_dout", 32'(cpu_dout), 32'h0FF);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 0;
    @(negedge clk);

    // Video fetch with a 3-cycle ack
    resp_delay = 3; resp_data = 16'hBEEF; vv_cnt = 0;
    ce_4p = 1; phase = 2'd0; vid_addr = 15'h1234;
    @(negedge clk);
    ce_4p = 0; phase = 2'd1;
    check("a_mem_req", 32'(mem_req), 32'(1));
    check("a_mem_addr", 32'(mem_addr), 32'h002468);
    check("a_mem_we", 32'(mem_we), 32'(0));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (vid_valid) found = 1;
    end
    check("a_vid_valid_seen", 32'(found), 32'(1));
    check("a_vid_dout", 32'(vid_dout), 32'h0BEEF);
    repeat (4) @(negedge clk);
    check("a_vid_pulses", 32'(vv_cnt), 32'(1));

    // CPU read of an odd byte
    cmd_q.delete(); resp_delay = 2; resp_data = 16'hA55A;
    cpu_rd = 1; cpu_addr = 23'h004001;
    @(negedge clk);
    check("b_ready_low", 32'(cpu_ready), 32'(0));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cpu_ready) found = 1;
    end
    check("b_ready_seen", 32'(found), 32'(1));
    check("b_cpu_dout", 32'(cpu_dout), 32'h0A5);
    repeat (4) @(negedge clk);
    check("b_ready_held", 32'(cpu_ready), 32'(1));
    check("b_cmd_count", 32'(cmd_q.size()), 32'(1));
    cpu_rd = 0;
    repeat (2) @(negedge clk);

    // CPU write and video tick together: video first
    cmd_q.delete(); resp_delay = 2; resp_data = 16'h0000;
    cpu_wr = 1; cpu_addr = 23'h012345; cpu_din = 8'h5A;
    ce_4p = 1; phase = 2'd0; vid_addr = 15'h0100;
    @(negedge clk);
    ce_4p = 0; phase = 2'd1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (cpu_ready) found = 1;
      else @(negedge clk);
    end
    check("c_ready_seen", 32'(found), 32'(1));
    check("c_cmd_count", 32'(cmd_q.size()), 32'(2));
    if (cmd_q.size() == 2) begin
      check("c_first_we", 32'(cmd_q[0][31]), 32'(0));
      check("c_first_addr", 32'(cmd_q[0][30:8]), 32'h000200);
      check("c_second_we", 32'(cmd_q[1][31]), 32'(1));
      check("c_second_addr", 32'(cmd_q[1][30:8]), 32'h012345);
      check("c_second_din", 32'(cmd_q[1][7:0]), 32'h05A);
    end
    cpu_wr = 0;
    repeat (2) @(negedge clk);

    // CPU read and DMA together: CPU first, one dma_ack, no DMA when disabled
    cmd_q.delete(); dack_cnt = 0; d2_dack_cnt = 0; d2_cmd_cnt = 0;
    cpu_rd = 1; cpu_addr = 23'h000777;
    dma_req = 1; dma_addr = 23'h07ABCD; dma_din = 8'hC3;
    for (int i = 0; i < 40 && (cpu_rd || dma_req); i++) begin
      @(negedge clk);
      if (cpu_rd && cpu_ready) cpu_rd = 0;
      if (dma_req && dma_ack) dma_req = 0;
    end
    repeat (4) @(negedge clk);
    check("d_dma_done", 32'(dma_req), 32'(0));
    check("d_cmd_count", 32'(cmd_q.size()), 32'(2));
    if (cmd_q.size() == 2) begin
      check("d_first_we", 32'(cmd_q[0][31]), 32'(0));
      check("d_first_addr", 32'(cmd_q[0][30:8]), 32'h000777);
      check("d_second_we", 32'(cmd_q[1][31]), 32'(1));
      check("d_second_addr", 32'(cmd_q[1][30:8]), 32'h07ABCD);
      check("d_second_din", 32'(cmd_q[1][7:0]), 32'h0C3);
    end
    check("d_dack_pulses", 32'(dack_cnt), 32'(1));
    check("d_nodma_dack", 32'(d2_dack_cnt), 32'(0));
    check("d_nodma_cmds", 32'(d2_cmd_cnt), 32'(1));

    // Reset during a video fetch, stale ack afterwards
    resp_en = 0; mem_ack = 0; vv_cnt = 0;
    ce_4p = 1; phase = 2'd0; vid_addr = 15'h0042;
    @(negedge clk);
    ce_4p = 0; phase = 2'd1;
    check("e_in_vid", 32'(dbg_state), 32'(ST_VID));
    reset = 1;
    @(negedge clk);
    reset = 0; vv_cnt = 0;
    @(negedge clk);
    mem_ack = 1; mem_dout = 16'h1111;
    @(negedge clk);
    mem_ack = 0;
    check("e_mem_req", 32'(mem_req), 32'(0));
    repeat (3) @(negedge clk);
    check("e_vid_pulses", 32'(vv_cnt), 32'(0));
    check("e_vid_dout", 32'(vid_dout), 32'(0));
    resp_en = 1; ack_sent = 0; resp_cnt = 0;

    // Randomized traffic
    resp_rand = 1; stray_en = 1; dma_next = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 599) == 0);
      ce_4p    = ($urandom_range(0, 3) == 0);
      phase    = 2'($urandom);
      vid_addr = 15'($urandom);
      if (cpu_rd || cpu_wr) begin
        if (cpu_ready) begin cpu_rd = 0; cpu_wr = 0; end
      end else if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 2);
        cpu_rd = (sel != 1); cpu_wr = (sel != 0);
        cpu_addr = 23'($urandom); cpu_din = 8'($urandom);
      end
      if (dma_next) begin
        dma_next = 0;
        if ($urandom_range(0, 1) == 0) dma_req = 0;
        else begin dma_addr = 23'($urandom); dma_din = 8'($urandom); end
      end else if (dma_req) begin
        if (dma_ack) dma_next = 1;
      end else if ($urandom_range(0, 7) == 0) begin
        dma_req = 1; dma_addr = 23'($urandom); dma_din = 8'($urandom);
      end
    end
    reset = 0; ce_4p = 0; cpu_rd = 0; cpu_wr = 0; dma_req = 0; stray_en = 0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
